// File: rtl/print_seq_ctrl.sv
// Printhead sequencing controller: validates operator requests against the
// power/platform state, issues one wave per request and tracks completion.
module print_seq_ctrl #(
  parameter int unsigned      N_CH       = 4,
  parameter int unsigned      TO_W       = 20,
  parameter logic [TO_W-1:0]  TO_LIMIT   = 20'hFFFFF,
  parameter logic [TO_W-1:0]  DOWN_LIMIT = 20'h7FFFF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  input  logic [3:0]      req_op,
  input  logic [N_CH-1:0] req_mask,
  output logic            req_ready,
  output logic            wave_req,
  output logic [3:0]      wave_op,
  output logic [N_CH-1:0] wave_mask,
  input  logic [N_CH-1:0] wave_end,
  output logic            wave_abort,
  output logic [2:0]      status,
  output logic [7:0]      err_code,
  output logic            err_pulse,
  output logic [7:0]      err_cnt,
  output logic            pto_down
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READY    = 3'd1,
    S_PLATFORM = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_PWRON  = 4'd0,
    OP_PWROFF = 4'd1,
    OP_FILL0  = 4'd2,
    OP_FILL1  = 4'd3,
    OP_UP     = 4'd4,
    OP_PRINT  = 4'd5,
    OP_DOWN   = 4'd6,
    OP_SHK_BF = 4'd7,
    OP_SHK_BT = 4'd8,
    OP_SHK_UP = 4'd9,
    OP_SHK_DN = 4'd10
  } op_e;

  localparam logic [TO_W-1:0] TO_LAST   = TO_LIMIT - TO_W'(1);
  localparam logic [TO_W-1:0] DOWN_LAST = DOWN_LIMIT - TO_W'(1);

  state_e          state, state_d, tgt_q, op_tgt, ld_tgt;
  op_e             op_in;
  logic            accept, op_legal;
  logic            issue_ld, up_ld, err_ld, timeout, complete;
  logic [3:0]      ld_op;
  logic [N_CH-1:0] ld_mask, up_mask, done_acc, hit;
  logic [7:0]      err_val;
  logic [TO_W-1:0] to_cnt, idle_cnt;

  assign op_in     = op_e'(req_op);
  assign req_ready = (state == S_IDLE) || (state == S_READY) || (state == S_PLATFORM);
  assign accept    = req_valid && req_ready;
  assign wave_req  = (state == S_ISSUE);
  assign status    = state;
  assign hit       = wave_end & wave_mask;

  // Legal transition table: which opcodes each resting state accepts.
  always_comb begin
    op_legal = 1'b0;
    op_tgt   = S_IDLE;
    case (state)
      S_IDLE: begin
        if (op_in == OP_PWRON) begin
          op_legal = 1'b1;
          op_tgt   = S_READY;
        end
      end
      S_READY: begin
        case (op_in)
          OP_PWROFF:                     begin op_legal = 1'b1; op_tgt = S_IDLE;     end
          OP_FILL0, OP_FILL1, OP_SHK_BT: begin op_legal = 1'b1; op_tgt = S_READY;    end
          OP_UP, OP_SHK_UP:              begin op_legal = 1'b1; op_tgt = S_PLATFORM; end
          default: ;
        endcase
      end
      S_PLATFORM: begin
        case (op_in)
          OP_PRINT:                      begin op_legal = 1'b1; op_tgt = S_PLATFORM; end
          OP_DOWN, OP_SHK_BF, OP_SHK_DN: begin op_legal = 1'b1; op_tgt = S_READY;    end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    issue_ld = 1'b0;
    up_ld    = 1'b0;
    ld_op    = '0;
    ld_mask  = '0;
    ld_tgt   = S_IDLE;
    err_ld   = 1'b0;
    err_val  = '0;
    timeout  = 1'b0;
    complete = 1'b0;
    pto_down = 1'b0;
    case (state)
      S_IDLE, S_READY, S_PLATFORM: begin
        if (accept) begin
          if (!op_legal) begin
            err_ld  = 1'b1;
            err_val = {4'h0, req_op} + 8'd1;
          end else if (req_mask == '0) begin
            err_ld  = 1'b1;
            err_val = 8'h20;
          end else begin
            issue_ld = 1'b1;
            ld_op    = req_op;
            ld_mask  = req_mask;
            ld_tgt   = op_tgt;
            up_ld    = (op_in == OP_UP) || (op_in == OP_SHK_UP);
            state_d  = S_ISSUE;
          end
        end else if (state == S_PLATFORM && DOWN_LIMIT != '0 && idle_cnt == DOWN_LAST) begin
          // Auto-down only when no external request is accepted this cycle.
          pto_down = 1'b1;
          issue_ld = 1'b1;
          ld_op    = OP_DOWN;
          ld_mask  = up_mask;
          ld_tgt   = S_READY;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if ((done_acc | hit) == wave_mask) begin
          complete = 1'b1;
          state_d  = tgt_q;
        end else if (to_cnt == TO_LAST) begin
          timeout = 1'b1;
          err_ld  = 1'b1;
          err_val = 8'h30;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wave_op    <= '0;
      wave_mask  <= '0;
      tgt_q      <= S_IDLE;
      up_mask    <= '0;
      done_acc   <= '0;
      to_cnt     <= '0;
      idle_cnt   <= '0;
      err_code   <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      wave_abort <= 1'b0;
    end else begin
      if (issue_ld) begin
        wave_op   <= ld_op;
        wave_mask <= ld_mask;
        tgt_q     <= ld_tgt;
      end
      if (up_ld) up_mask <= req_mask;

      if (state == S_WAIT && !complete && !timeout) done_acc <= done_acc | hit;
      else                                          done_acc <= '0;

      if (state == S_WAIT) to_cnt <= to_cnt + TO_W'(1);
      else                 to_cnt <= '0;

      if (state == S_PLATFORM && state_d == S_PLATFORM && !accept) idle_cnt <= idle_cnt + TO_W'(1);
      else                                                         idle_cnt <= '0;

      err_pulse  <= err_ld;
      wave_abort <= timeout;
      if (err_ld) begin
        err_code <= err_val;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_print_seq_ctrl.sv
// Directed plus randomized checks of print_seq_ctrl against a transaction-level
// model built from a legal-transition table.
module tb_print_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid;
  logic [3:0] req_op;
  logic [3:0] req_mask;
  logic       req_ready;
  logic       wave_req;
  logic [3:0] wave_op;
  logic [3:0] wave_mask;
  logic [3:0] wave_end;
  logic       wave_abort;
  logic [2:0] status;
  logic [7:0] err_code;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic       pto_down;

  int         total = 0;
  int         bad   = 0;
  int         mstate;
  int         mcnt;
  logic [7:0] mcode;
  logic [3:0] mup;
  int         tgt_tab[3][16];

  localparam int TO_LIM = 40;
  localparam int DN_LIM = 16;

  print_seq_ctrl #(
    .N_CH(4),
    .TO_W(20),
    .TO_LIMIT(20'd40),
    .DOWN_LIMIT(20'd16)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_op(req_op),
    .req_mask(req_mask), .req_ready(req_ready), .wave_req(wave_req),
    .wave_op(wave_op), .wave_mask(wave_mask), .wave_end(wave_end),
    .wave_abort(wave_abort), .status(status), .err_code(err_code),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .pto_down(pto_down)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic log_err(input logic [7:0] code);
    mcode = code;
    if (mcnt < 255) mcnt++;
  endtask

  // Deliver per-channel completions one at a time in random order, with
  // random gaps and stray pulses on channels outside the mask.
  task automatic finish_wave(input logic [3:0] m, input int tgt);
    logic [3:0] left;
    int         ch;
    int         guard;
    left  = m;
    guard = 0;
    while (left != 4'h0 && guard < 200) begin
      guard++;
      ch = $urandom_range(0, 3);
      if (left[ch]) begin
        repeat ($urandom_range(0, 2)) begin
          wave_end = ~m & 4'($urandom);
          step();
          chk("wait_hold", status, 4);
        end
        wave_end  = (4'b0001 << ch) | (~m & 4'($urandom));
        left[ch] = 1'b0;
        step();
        if (left == 4'h0) chk("wave_done", status, tgt);
        else              chk("wave_part", status, 4);
        wave_end = 4'h0;
      end
    end
    if (left != 4'h0) chk("wave_guard", left, 0);
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] m, input bit do_finish);
    int         t;
    bit         err;
    logic [7:0] code;
    t    = tgt_tab[mstate][op];
    err  = 1'b0;
    code = 8'h00;
    if (t < 0)           begin err = 1'b1; code = 8'(op) + 8'd1; end
    else if (m == 4'h0)  begin err = 1'b1; code = 8'h20; end
    req_valid = 1'b1;
    req_op    = op;
    req_mask  = m;
    #1;
    chk("req_ready", req_ready, 1);
    chk("no_pto_on_req", pto_down, 0);
    step();
    req_valid = 1'b0;
    if (err) begin
      log_err(code);
      chk("err_pulse", err_pulse, 1);
      chk("err_code", err_code, mcode);
      chk("err_cnt", err_cnt, mcnt);
      chk("err_state", status, mstate);
      chk("err_no_wave", wave_req, 0);
      step();
      chk("err_pulse_off", err_pulse, 0);
      chk("err_code_hold", err_code, mcode);
    end else begin
      if (op == 4'd4 || op == 4'd9) mup = m;
      chk("issue_state", status, 3);
      chk("issue_req", wave_req, 1);
      chk("issue_op", wave_op, op);
      chk("issue_mask", wave_mask, m);
      step();
      chk("wait_state", status, 4);
      chk("wave_req_off", wave_req, 0);
      if (do_finish) begin
        finish_wave(m, t);
        chk("hold_op", wave_op, op);
        mstate = t;
      end
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [3:0] m;

    foreach (tgt_tab[s, o]) tgt_tab[s][o] = -1;
    tgt_tab[0][0]  = 1;
    tgt_tab[1][1]  = 0;
    tgt_tab[1][2]  = 1;  tgt_tab[1][3]  = 1;  tgt_tab[1][8]  = 1;
    tgt_tab[1][4]  = 2;  tgt_tab[1][9]  = 2;
    tgt_tab[2][5]  = 2;
    tgt_tab[2][6]  = 1;  tgt_tab[2][7]  = 1;  tgt_tab[2][10] = 1;

    mstate = 0; mcnt = 0; mcode = 8'h00; mup = 4'h0;
    rstn = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_mask = 4'h0; wave_end = 4'h0;
    #3;
    chk("rst_status", status, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_wave_req", wave_req, 0);
    chk("rst_abort", wave_abort, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wave_op", wave_op, 0);
    chk("rst_wave_mask", wave_mask, 0);
    chk("rst_pto", pto_down, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // Power-on with two channels completing on separate cycles.
    send(4'd0, 4'b0011, 1'b0);
    wave_end = 4'b0001; step(); chk("pwron_part", status, 4);
    wave_end = 4'b0000; step(); chk("pwron_gap", status, 4);
    wave_end = 4'b0010; step(); chk("pwron_ready", status, 1);
    wave_end = 4'b0000;
    mstate = 1;

    // Illegal op in READY, twice, then an empty mask.
    send(4'd5, 4'b0001, 1'b1);
    send(4'd5, 4'b0001, 1'b1);
    chk("err_cnt_two", err_cnt, 2);
    send(4'd2, 4'b0000, 1'b1);

    // Masked completion with stray pulses, then stray pulses while resting.
    send(4'd3, 4'b0101, 1'b1);
    wave_end = 4'hF;
    step(); chk("stray_state", status, 1);
    chk("stray_no_wave", wave_req, 0);
    step(); chk("stray_no_err", err_pulse, 0);
    chk("stray_err_cnt", err_cnt, mcnt);
    wave_end = 4'h0;

    // Auto-down after sixteen idle PLATFORM cycles.
    send(4'd4, 4'b1011, 1'b1);
    for (int i = 1; i < DN_LIM; i++) begin
      chk("pto_early", pto_down, 0);
      chk("plat_state", status, 2);
      step();
    end
    chk("pto_fire", pto_down, 1);
    step();
    chk("pto_issue", wave_req, 1);
    chk("pto_op", wave_op, 6);
    chk("pto_mask", wave_mask, mup);
    step();
    finish_wave(4'b1011, 1);
    mstate = 1;

    // External request on the would-be auto-down cycle wins.
    send(4'd9, 4'b0110, 1'b1);
    for (int i = 1; i < DN_LIM; i++) step();
    send(4'd5, 4'b0010, 1'b1);
    send(4'd6, 4'b0110, 1'b1);

    // Timeout with no completions.
    send(4'd4, 4'b1111, 1'b0);
    for (int i = 1; i <= TO_LIM; i++) begin
      chk("to_wait", status, 4);
      step();
    end
    log_err(8'h30);
    mstate = 0;
    chk("to_status", status, 0);
    chk("to_abort", wave_abort, 1);
    chk("to_err_code", err_code, 8'h30);
    chk("to_err_pulse", err_pulse, 1);
    chk("to_err_cnt", err_cnt, mcnt);
    step();
    chk("to_abort_off", wave_abort, 0);

    // Reset in the middle of a wave.
    send(4'd0, 4'b0001, 1'b0);
    step();
    #2 rstn = 1'b0;
    #1;
    chk("midrst_status", status, 0);
    chk("midrst_abort", wave_abort, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_mask", wave_mask, 0);
    step();
    rstn = 1'b1;
    mstate = 0; mcnt = 0; mcode = 8'h00; mup = 4'h0;
    step();
    chk("postrst_abort", wave_abort, 0);
    chk("postrst_status", status, 0);

    // Randomized request stream.
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0)
        for (int k = 0; k < 64 && tgt_tab[mstate][op] < 0; k++) op = 4'($urandom_range(0, 15));
      m = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      send(op, m, 1'b1);
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) send(4'd15, 4'b0001, 1'b1);
    chk("err_sat", err_cnt, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
